// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor (Diff = A - B), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module n_bit_serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         Borrow,
    output logic         Overflow
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_sr, b_sr, res;
    logic          br;
    logic [CW-1:0] cnt;

    logic          a, b, d, br_nxt, last;
    logic [N:0]    res_cat;

    assign a       = a_sr[0];
    assign b       = b_sr[0];
    assign d       = a ^ b ^ br;
    assign br_nxt  = (~a & b) | (~(a ^ b) & br);
    // Concatenate then drop the LSB so the N=1 case needs no special slicing.
    assign res_cat = {d, res};
    assign last    = (cnt == CW'(N - 1));

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_nxt;
                    res  <= res_cat[N:1];
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        // Publish the completed result as DONE is entered.
                        Diff   <= res_cat[N:1];
                        Borrow <= br_nxt;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SUB_OVF_EN
    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk) begin
        if (rst)
            Overflow <= 1'b0;
        else if (state == S_SHIFT && last)
            Overflow <= br ^ br_nxt;
    end
`else
    assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Scoreboard bench for n_bit_serial_subtractor: arithmetic reference model,
// cycle-accurate acceptance model, decoupled monitor.
module tb_n_bit_serial_subtractor;
    localparam int N = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk, rst, start;
    logic [N-1:0] A, B;
    logic         busy, done, Borrow, Overflow;
    logic [N-1:0] Diff;

    n_bit_serial_subtractor #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Diff(Diff), .Borrow(Borrow), .Overflow(Overflow)
    );

    typedef struct {
        int unsigned diff;
        bit          borrow;
        bit          ovf;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          busy_left = 0;
    bit          last_rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int unsigned hold_d = 0;
    bit          hold_b = 0, hold_o = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned due);
        exp_t e;
        int   sd;
        e.diff   = (a - b) & MASK;
        e.borrow = (a < b);
        // Signed overflow from two's-complement interpretation of the operands.
        sd = ((a >= (1 << (N-1))) ? int'(a) - (1 << N) : int'(a))
           - ((b >= (1 << (N-1))) ? int'(b) - (1 << N) : int'(b));
`ifdef SUB_OVF_EN
        e.ovf = (sd > (1 << (N-1)) - 1) || (sd < -(1 << (N-1)));
`else
        e.ovf = 1'b0;
`endif
        e.due = due;
        return e;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Acceptance model: an op occupies N+1 cycles; start is seen only when idle.
    always @(posedge clk) begin
        last_rst = rst;
        if (rst) begin
            q.delete();
            busy_left = 0;
        end else if (busy_left == 0 && start) begin
            q.push_back(model(A, B, cyc + N + 1));
            busy_left = N + 1;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
        end
        cyc <= cyc + 1;
    end

    // Monitor: sampled mid-cycle.
    always @(negedge clk) begin
        if (last_rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_diff", Diff, 0);
            chk("rst_borrow", Borrow, 0);
            chk("rst_ovf", Overflow, 0);
            hold_d = 0; hold_b = 0; hold_o = 0;
        end else begin
            chk("busy", busy, busy_left > 0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("diff", Diff, e.diff);
                    chk("borrow", Borrow, e.borrow);
                    chk("ovf", Overflow, e.ovf);
                    hold_d = e.diff; hold_b = e.borrow; hold_o = e.ovf;
                end
            end else begin
                if (q.size() != 0 && cyc > q[0].due) begin
                    chk("missing_done", 0, 1);
                    void'(q.pop_front());
                end
                if (Diff != hold_d || Borrow != hold_b || Overflow != hold_o)
                    chk("hold", {Diff, Borrow, Overflow}, {hold_d[N-1:0], hold_b, hold_o});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
        start = 1'b1; A = a; B = b;
        tick(1);
        start = 1'b0; A = N'($urandom); B = N'($urandom);
        tick(N + 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        tick(2);
        rst = 1'b0;
        tick(1);

        op(4'b0010, 4'b1111);
        op(4'b1100, 4'b1001);
        op(4'b1101, 4'b1101);
        op(4'b0111, 4'b1000);
        op(4'b1000, 4'b0001);

        // start pulses during an op must be ignored
        start = 1'b1; A = 4'b0110; B = 4'b0011;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1; A = 4'b1111; B = 4'b0000;
        tick(2);
        start = 1'b0;
        tick(N);

        // reset mid-op aborts with no done
        start = 1'b1; A = 4'b1001; B = 4'b0100;
        tick(1);
        start = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(N + 2);
        op(4'b0101, 4'b1110);

        // continuous start, random operands every cycle
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            A = N'($urandom); B = N'($urandom);
            tick(1);
        end
        start = 1'b0;

        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        chk("queue_drained", q.size(), 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
